// File: rtl/beam_power_acc_pkg.sv
// Shared types and default sizing for the beam power accumulator.
package beam_power_acc_pkg;

    // Default geometry: 16 beams, 32-bit complex samples, 48-bit energy.
    localparam int BEAM_DEF = 16;
    localparam int OW_DEF   = 32;
    localparam int AW_DEF   = 48;

    // Output drain controller states.
    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } drain_state_e;

endpackage : beam_power_acc_pkg

// File: rtl/beam_power_acc_cplx_pwr.sv
// Per-beam |x|^2: stage P1 squares I and Q, stage P2 adds them.
module cplx_pwr
    import beam_power_acc_pkg::*;
#(
    parameter int OW = OW_DEF
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic [OW-1:0] i_data,
    output logic [OW:0]   o_pwr
);

    localparam int HW = OW / 2;

    logic signed [OW-1:0] re_ext;
    logic signed [OW-1:0] im_ext;
    logic        [OW-1:0] re_sq_q;
    logic        [OW-1:0] im_sq_q;
    logic        [OW:0]   pwr_q;

    // Sign-extend each half so the OW-bit product holds the full square.
    assign re_ext = {{(OW - HW){i_data[HW-1]}}, i_data[HW-1:0]};
    assign im_ext = {{(OW - HW){i_data[OW-1]}}, i_data[OW-1:HW]};

    // P1: register I^2 and Q^2 (always non-negative, fit in OW bits).
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            re_sq_q <= '0;
            im_sq_q <= '0;
        end else begin
            re_sq_q <= re_ext * re_ext;
            im_sq_q <= im_ext * im_ext;
        end
    end

    // P2: register I^2 + Q^2 with one bit of growth.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            pwr_q <= '0;
        end else begin
            pwr_q <= {1'b0, re_sq_q} + {1'b0, im_sq_q};
        end
    end

    assign o_pwr = pwr_q;

endmodule : cplx_pwr

// File: rtl/beam_power_acc.sv
// Per-beam energy accumulation over a symbol with shadow-bank readout.
module beam_power_acc
    import beam_power_acc_pkg::*;
#(
    parameter int BEAM = BEAM_DEF,
    parameter int OW   = OW_DEF,
    parameter int AW   = AW_DEF,
    parameter int BW   = $clog2(BEAM)
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic [BEAM-1:0][OW-1:0]   i_sum_data,
    input  logic                      i_tvalid,
    input  logic                      i_sym_last,
    output logic [AW-1:0]             o_pwr_data,
    output logic [BW-1:0]             o_beam_idx,
    output logic                      o_pwr_valid,
    input  logic                      i_pwr_ready,
    output logic                      o_pwr_last,
    output logic                      o_overrun,
    output logic                      o_sat
);

    // Adder width wide enough for either operand plus a carry.
    localparam int SW = ((AW > OW + 1) ? AW : OW + 1) + 1;

    logic [BEAM-1:0][OW:0]   pwr;
    logic [BEAM-1:0][SW-1:0] sum_w;
    logic [BEAM-1:0][AW-1:0] acc_nxt;
    logic [BEAM-1:0][AW-1:0] acc_q;
    logic [BEAM-1:0][AW-1:0] shd_q;
    logic [BEAM-1:0]         sat_vec;

    logic v1_q, l1_q, v2_q, l2_q;
    logic pend_q, o_pwr_valid_q, o_overrun_q, o_sat_q;
    logic [BW-1:0] idx_q;
    drain_state_e  state_q;

    logic hs, last_beam, fin_hs, snap, busy, accept, drop;

    for (genvar b = 0; b < BEAM; b++) begin : g_pwr
        cplx_pwr #(.OW(OW)) u_cplx_pwr (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .i_data  (i_sum_data[b]),
            .o_pwr   (pwr[b])
        );
    end

    // Delay valid/last alongside the two power stages.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            v1_q <= 1'b0;
            l1_q <= 1'b0;
            v2_q <= 1'b0;
            l2_q <= 1'b0;
        end else begin
            v1_q <= i_tvalid;
            l1_q <= i_tvalid & i_sym_last;
            v2_q <= v1_q;
            l2_q <= l1_q;
        end
    end

    // Saturating per-beam sum of the current accumulator and P2 power.
    always_comb begin
        sum_w   = '0;
        acc_nxt = '0;
        sat_vec = '0;
        for (int unsigned b = 0; b < BEAM; b++) begin
            sum_w[b]   = SW'(acc_q[b]) + SW'(pwr[b]);
            sat_vec[b] = |sum_w[b][SW-1:AW];
            acc_nxt[b] = sat_vec[b] ? '1 : sum_w[b][AW-1:0];
        end
    end

    // Snapshot admission: the bank is busy while draining or about to drain,
    // except in the cycle that hands off the last beam.
    always_comb begin
        hs        = o_pwr_valid_q & i_pwr_ready;
        last_beam = (idx_q == BW'(BEAM - 1));
        fin_hs    = hs & last_beam;
        snap      = v2_q & l2_q;
        busy      = ((state_q == DRAIN) & ~fin_hs) | pend_q;
        accept    = snap & ~busy;
        drop      = snap & busy;
    end

    // Stage A: accumulate, restart on symbol end, capture into the shadow bank.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            acc_q   <= '0;
            shd_q   <= '0;
            o_sat_q <= 1'b0;
        end else begin
            if (v2_q) begin
                for (int unsigned b = 0; b < BEAM; b++) begin
                    acc_q[b] <= l2_q ? '0 : acc_nxt[b];
                end
                if (|sat_vec) begin
                    o_sat_q <= 1'b1;
                end
            end
            if (accept) begin
                shd_q <= acc_nxt;
            end
        end
    end

    // Drain FSM; a fresh snapshot from IDLE waits one cycle in pend_q so the
    // first word appears four cycles after the last input sample.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            pend_q        <= 1'b0;
            o_pwr_valid_q <= 1'b0;
            o_overrun_q   <= 1'b0;
        end else begin
            pend_q <= accept & (state_q == IDLE);
            if (drop) begin
                o_overrun_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    idx_q <= '0;
                    if (pend_q) begin
                        state_q       <= DRAIN;
                        o_pwr_valid_q <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (hs) begin
                        if (last_beam) begin
                            idx_q <= '0;
                            if (!accept) begin
                                state_q       <= IDLE;
                                o_pwr_valid_q <= 1'b0;
                            end
                        end else begin
                            idx_q <= idx_q + BW'(1);
                        end
                    end
                end
                default: begin
                    state_q       <= IDLE;
                    o_pwr_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_pwr_valid = o_pwr_valid_q;
    assign o_beam_idx  = idx_q;
    assign o_pwr_last  = o_pwr_valid_q & last_beam;
    assign o_pwr_data  = o_pwr_valid_q ? shd_q[idx_q] : '0;
    assign o_overrun   = o_overrun_q;
    assign o_sat       = o_sat_q;

endmodule : beam_power_acc

// File: tb/tb_beam_power_acc.sv
// Randomised bench for beam_power_acc against a transaction-level model.
module tb_beam_power_acc;

    localparam int BEAM = 16;
    localparam int OW   = 32;
    localparam int AW   = 32;
    localparam int BW   = 4;
    localparam int BIG  = 32'h3fff_ffff;
    localparam longint unsigned MAXV = 64'h0000_0000_ffff_ffff;

    typedef logic [BEAM-1:0][OW-1:0] din_t;
    typedef logic [BEAM-1:0][AW-1:0] vec_t;

    logic          clk = 1'b0;
    logic          rst;
    din_t          sum_data;
    logic          tvalid, sym_last, pwr_ready;
    logic [AW-1:0] pwr_data;
    logic [BW-1:0] beam_idx;
    logic          pwr_valid, pwr_last, overrun, sat;

    always #5 clk = ~clk;

    beam_power_acc #(.BEAM(BEAM), .OW(OW), .AW(AW)) u_dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_sum_data  (sum_data),
        .i_tvalid    (tvalid),
        .i_sym_last  (sym_last),
        .o_pwr_data  (pwr_data),
        .o_beam_idx  (beam_idx),
        .o_pwr_valid (pwr_valid),
        .i_pwr_ready (pwr_ready),
        .o_pwr_last  (pwr_last),
        .o_overrun   (overrun),
        .o_sat       (sat)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive values for the next cycle.
    bit   d_rst, d_tv, d_last, d_rdy;
    din_t d_data;

    // Reference model: running sums, pending snapshots, word being emitted.
    longint unsigned macc[BEAM];
    vec_t            snap_v[$];
    int              snap_at[$];
    vec_t            cur;
    bit              active;
    int              m_idx, start, sat_from, ovr_from, cyc;
    bit              chk_zero;

    // Observations used by scenario-level checks.
    longint unsigned cap[BEAM];
    int              first_v, hs_cnt, last_cyc;

    task automatic model_clear();
        for (int b = 0; b < BEAM; b++) macc[b] = 0;
        snap_v.delete();
        snap_at.delete();
        active   = 1'b0;
        m_idx    = 0;
        start    = 0;
        sat_from = BIG;
        ovr_from = BIG;
    endtask

    task automatic tick();
        bit ev, hs, fin;
        vec_t nv;
        int arr;
        longint ii, qq;
        longint unsigned s;
        logic signed [15:0] hi, hq;
        @(negedge clk);
        rst       = d_rst;
        sum_data  = d_data;
        tvalid    = d_tv;
        sym_last  = d_last;
        pwr_ready = d_rdy;
        ev = active && (cyc >= start);
        check_val("valid", pwr_valid, ev);
        if (ev) begin
            check_val("beam_idx", beam_idx, m_idx);
            check_val("pwr_data", pwr_data, cur[m_idx]);
            check_val("pwr_last", pwr_last, m_idx == BEAM - 1);
        end
        check_val("sat", sat, cyc >= sat_from);
        check_val("overrun", overrun, cyc >= ovr_from);
        if (chk_zero) begin
            check_val("rst_data", pwr_data, 0);
            check_val("rst_idx", beam_idx, 0);
            check_val("rst_last", pwr_last, 0);
            chk_zero = 1'b0;
        end
        if (pwr_valid && first_v < 0) first_v = cyc;
        if (pwr_valid && d_rdy) begin
            cap[beam_idx] = pwr_data;
            hs_cnt++;
        end
        if (d_rst) begin
            model_clear();
            chk_zero = 1'b1;
        end else begin
            hs  = ev && d_rdy;
            fin = hs && (m_idx == BEAM - 1);
            if (snap_at.size() > 0 && snap_at[0] == cyc) begin
                nv  = snap_v.pop_front();
                arr = snap_at.pop_front();
                if (active && !fin) begin
                    if (ovr_from > arr + 1) ovr_from = arr + 1;
                end else begin
                    start  = fin ? cyc + 1 : cyc + 2;
                    cur    = nv;
                    m_idx  = 0;
                    active = 1'b1;
                    hs     = 1'b0;
                    fin    = 1'b0;
                end
            end
            if (hs) begin
                if (fin) active = 1'b0;
                else m_idx++;
            end
            if (d_tv) begin
                for (int b = 0; b < BEAM; b++) begin
                    hi = d_data[b][15:0];
                    hq = d_data[b][31:16];
                    ii = hi;
                    qq = hq;
                    s  = macc[b] + longint'(ii * ii + qq * qq);
                    if (s > MAXV) begin
                        s = MAXV;
                        if (sat_from > cyc + 3) sat_from = cyc + 3;
                    end
                    macc[b] = s;
                end
                if (d_last) begin
                    for (int b = 0; b < BEAM; b++) nv[b] = macc[b][AW-1:0];
                    snap_v.push_back(nv);
                    snap_at.push_back(cyc + 2);
                    for (int b = 0; b < BEAM; b++) macc[b] = 0;
                end
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        d_tv   = 1'b0;
        d_last = 1'b0;
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic send(input din_t v, input bit l);
        d_data = v;
        d_tv   = 1'b1;
        d_last = l;
        if (l) last_cyc = cyc;
        tick();
        d_tv   = 1'b0;
        d_last = 1'b0;
    endtask

    task automatic do_reset();
        d_rst = 1'b1;
        idle(2);
        d_rst = 1'b0;
        idle(1);
    endtask

    function automatic din_t ramp_vec();
        din_t v;
        for (int b = 0; b < BEAM; b++) v[b] = {16'd1, 16'(b)};
        return v;
    endfunction

    function automatic din_t rnd_vec(input bit full);
        din_t v;
        int   x, y;
        for (int b = 0; b < BEAM; b++) begin
            if (full) begin
                v[b] = $urandom;
            end else begin
                x = int'($urandom_range(0, 255)) - 128;
                y = int'($urandom_range(0, 255)) - 128;
                v[b] = {y[15:0], x[15:0]};
            end
        end
        return v;
    endfunction

    task automatic drain_all();
        d_rdy = 1'b1;
        for (int k = 0; k < 300 && (active || snap_at.size() > 0); k++) idle(1);
        check_val("drain_timeout", active || snap_at.size() > 0, 0);
        idle(2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        d_rst = 1'b0; d_tv = 1'b0; d_last = 1'b0; d_rdy = 1'b1;
        d_data = '0; cyc = 0; chk_zero = 1'b0; last_cyc = 0;
        model_clear();
        do_reset();

        // Single symbol, four REs of I=b, Q=1.
        first_v = -1;
        for (int r = 0; r < 4; r++) send(ramp_vec(), r == 3);
        drain_all();
        check_val("first_latency", first_v - last_cyc, 4);
        for (int b = 0; b < BEAM; b++) check_val("ramp_word", cap[b], 4 * (b * b + 1));

        // Same symbol, ready toggling every cycle.
        hs_cnt = 0;
        for (int r = 0; r < 4; r++) send(ramp_vec(), r == 3);
        for (int k = 0; k < 50; k++) begin
            d_rdy = k[0];
            idle(1);
        end
        drain_all();
        check_val("toggle_count", hs_cnt, BEAM);

        // Second last lands exactly on the final handshake.
        hs_cnt = 0;
        for (int r = 0; r < 4; r++) send(rnd_vec(1'b0), r == 3);
        idle(13);
        for (int r = 0; r < 4; r++) send(rnd_vec(1'b0), r == 3);
        drain_all();
        check_val("aligned_count", hs_cnt, 2 * BEAM);
        check_val("aligned_no_ovr", overrun, 0);

        // Second symbol ends mid-drain with ready held low.
        hs_cnt = 0;
        d_rdy  = 1'b0;
        for (int r = 0; r < 4; r++) send(rnd_vec(1'b0), r == 3);
        idle(4);
        for (int r = 0; r < 2; r++) send(rnd_vec(1'b0), r == 1);
        idle(6);
        drain_all();
        check_val("drop_count", hs_cnt, BEAM);
        check_val("drop_ovr", overrun, 1);
        do_reset();

        // Most negative I and Q on all beams saturates a 32-bit accumulator.
        for (int r = 0; r < 3; r++) send({BEAM{32'h8000_8000}}, r == 2);
        drain_all();
        check_val("sat_flag", sat, 1);
        check_val("sat_word", cap[BEAM-1], MAXV);
        do_reset();

        // Reset while beam 5 is on the output.
        for (int r = 0; r < 3; r++) send(rnd_vec(1'b0), r == 2);
        for (int k = 0; k < 40 && !(active && cyc >= start && m_idx == 5); k++) idle(1);
        check_val("reach_beam5", m_idx, 5);
        d_rst = 1'b1;
        idle(1);
        d_rst = 1'b0;
        idle(1);
        for (int r = 0; r < 3; r++) send(rnd_vec(1'b0), r == 2);
        drain_all();

        // Random traffic with bubbles, stalls and occasional large samples.
        for (int k = 0; k < 500; k++) begin
            d_rst  = (k == 250);
            d_rdy  = ($urandom_range(0, 9) < 6);
            d_tv   = ($urandom_range(0, 9) < 7);
            d_last = d_tv && ($urandom_range(0, 5) == 0);
            d_data = rnd_vec($urandom_range(0, 19) == 0);
            tick();
        end
        d_rst = 1'b0;
        d_tv  = 1'b0;
        d_last = 1'b0;
        drain_all();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_beam_power_acc
